// File: rtl/mont_pkg.sv
// Shared definitions for the Montgomery-domain conversion block.
package mont_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mont_state_e;

  // Number of RUN cycles needed to apply LOGR doublings at D per clock.
  function automatic int to_mont_lat(input int logr, input int d);
    return logr / d;
  endfunction

endpackage

// File: rtl/to_mont_if.sv
// Operand/result handshake bundle for to_mont.
interface to_mont_if #(
  parameter int LOGQ = 60
);
  logic            in_valid;
  logic            in_ready;
  logic [LOGQ-1:0] q;
  logic [LOGQ-1:0] a;
  logic            out_valid;
  logic            out_ready;
  logic [LOGQ-1:0] T;

  modport master (
    output in_valid, q, a, out_ready,
    input  in_ready, out_valid, T
  );

  modport slave (
    input  in_valid, q, a, out_ready,
    output in_ready, out_valid, T
  );
endinterface

// File: rtl/to_mont_moddbl.sv
// One modular doubling: y = 2x mod q for x < q. The doubled value keeps its
// carry bit so the compare against q sees the full LOGQ+1 bit quantity.
module moddbl #(
  parameter int LOGQ = 60
) (
  input  logic [LOGQ-1:0] x_i,
  input  logic [LOGQ-1:0] q_i,
  output logic [LOGQ-1:0] y_o
);
  logic [LOGQ:0] dbl_w;
  logic          ge_w;

  assign dbl_w = {x_i, 1'b0};
  assign ge_w  = (dbl_w >= {1'b0, q_i});
  assign y_o   = ge_w ? LOGQ'(dbl_w - {1'b0, q_i}) : dbl_w[LOGQ-1:0];
endmodule

// File: rtl/to_mont.sv
// Converts an operand a (< 2q) into Montgomery form T = a * 2^LOGR mod q by
// repeated modular doubling, D doublings per clock.
//
// state | meaning
// IDLE  | waiting for an operand, in_ready=1
// RUN   | applying D doublings per cycle, LOGR/D cycles
// DONE  | result held on T with out_valid=1 until out_ready
module to_mont
  import mont_pkg::*;
#(
  parameter int LOGQ = 60,
  parameter int LOGR = 60,
  parameter int D    = 4
) (
  input logic       clk,
  input logic       rst,
  to_mont_if.slave  bus
);
  localparam int LAT = to_mont_lat(LOGR, D);
  localparam int CW  = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(LAT - 1);

  if ((LOGR % D) != 0) begin : g_cfg_err
    $error("to_mont: LOGR must be a multiple of D");
  end

  mont_state_e     state_q;
  logic [LOGQ-1:0] x_q;
  logic [LOGQ-1:0] q_lat_q;
  logic [CW-1:0]   cnt_q;
  logic            out_valid_q;

  logic            in_ready_d;
  logic            accept_d;
  logic [LOGQ-1:0] x_load_d;
  logic [LOGQ-1:0] chain_w [D+1];

  // Ready is a function of the registered state plus out_ready so that a
  // finished result can be retired and a new operand taken on the same edge.
  always_comb begin
    in_ready_d = 1'b0;
    unique case (state_q)
      IDLE:    in_ready_d = 1'b1;
      DONE:    in_ready_d = bus.out_ready;
      default: in_ready_d = 1'b0;
    endcase
  end

  assign accept_d = bus.in_valid & in_ready_d;
  // Operand may be up to 2q-1; one conditional subtract brings it below q.
  assign x_load_d = (bus.a >= bus.q) ? (bus.a - bus.q) : bus.a;

  assign chain_w[0] = x_q;
  for (genvar i = 0; i < D; i++) begin : g_dbl
    moddbl #(.LOGQ(LOGQ)) u_dbl (
      .x_i (chain_w[i]),
      .q_i (q_lat_q),
      .y_o (chain_w[i+1])
    );
  end

  // Sequencer: accept/load, D doublings per RUN cycle, hold result in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      x_q         <= '0;
      q_lat_q     <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else if (accept_d) begin
      state_q     <= RUN;
      x_q         <= x_load_d;
      q_lat_q     <= bus.q;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          out_valid_q <= 1'b0;
        end
        RUN: begin
          x_q <= chain_w[D];
          if (cnt_q == LAST_CNT) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_d;
  assign bus.out_valid = out_valid_q;
  assign bus.T         = x_q;
endmodule

// File: tb/tb_to_mont.sv
// Directed and reference-model checks for to_mont: a small 4-bit instance
// with hand-computed results and a default-size instance against a wide
// modulo reference.
module tb_to_mont;
  logic clk = 1'b0;
  logic rst_s;
  logic rst_l;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  to_mont_if #(.LOGQ(4))  sif ();
  to_mont_if #(.LOGQ(60)) lif ();

  to_mont #(.LOGQ(4), .LOGR(4), .D(1)) u_small (
    .clk (clk),
    .rst (rst_s),
    .bus (sif.slave)
  );

  to_mont u_big (
    .clk (clk),
    .rst (rst_l),
    .bus (lif.slave)
  );

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Single operand on the small instance; q/a are scrambled during RUN.
  task automatic small_op(input logic [3:0] av, input logic [3:0] exp_t, input string tag);
    int lat;
    sif.q = 4'd13; sif.a = av; sif.in_valid = 1'b1; sif.out_ready = 1'b1;
    @(posedge clk); #1;
    sif.in_valid = 1'b0; sif.q = 4'd3; sif.a = 4'd7;
    check_vec({tag, "_busy"}, 64'(sif.in_ready), 64'd0);
    lat = 0;
    while (!sif.out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    check_vec({tag, "_lat"}, 64'(lat), 64'd4);
    check_vec(tag, 64'(sif.T), 64'(exp_t));
    @(posedge clk); #1;
    check_vec({tag, "_ret"}, 64'(sif.out_valid), 64'd0);
  endtask

  task automatic big_op(input logic [59:0] qv, input logic [59:0] av, input logic [59:0] exp_t);
    int lat;
    lif.q = qv; lif.a = av; lif.in_valid = 1'b1; lif.out_ready = 1'b1;
    @(posedge clk); #1;
    lif.in_valid = 1'b0; lif.a = ~av; lif.q = qv ^ 60'h5a5;
    lat = 0;
    while (!lif.out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    check_vec("big_lat", 64'(lat), 64'd15);
    check_vec("big_T", 64'(lif.T), 64'(exp_t));
    @(posedge clk); #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int seen;
    logic [63:0]  r;
    logic [59:0]  qv, av, ev;
    logic [60:0]  sum;
    logic [119:0] prod;

    rst_s = 1'b1; rst_l = 1'b1;
    sif.in_valid = 1'b0; sif.out_ready = 1'b0; sif.q = '0; sif.a = '0;
    lif.in_valid = 1'b0; lif.out_ready = 1'b0; lif.q = '0; lif.a = '0;
    #1;
    check_vec("rst_in_ready", 64'(sif.in_ready), 64'd1);
    check_vec("rst_out_valid", 64'(sif.out_valid), 64'd0);
    check_vec("rst_T", 64'(sif.T), 64'd0);
    check_vec("rst_big_in_ready", 64'(lif.in_ready), 64'd1);
    @(posedge clk); @(posedge clk); #1;
    rst_s = 1'b0; rst_l = 1'b0;

    // Hand-computed: 5*16=80=6*13+2, 12*16=192=14*13+10, 15->2->32=2*13+6.
    small_op(4'd5,  4'd2,  "a5");
    small_op(4'd12, 4'd10, "a12");
    small_op(4'd0,  4'd0,  "a0");
    small_op(4'd15, 4'd6,  "a15");

    // Back-to-back: retire 5 and accept 12 on the same edge.
    sif.q = 4'd13; sif.a = 4'd5; sif.in_valid = 1'b1; sif.out_ready = 1'b1;
    @(posedge clk); #1;
    sif.a = 4'd12;
    lat = 0;
    while (!sif.out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    check_vec("b2b_lat0", 64'(lat), 64'd4);
    check_vec("b2b_T0", 64'(sif.T), 64'd2);
    check_vec("b2b_rdy0", 64'(sif.in_ready), 64'd1);
    @(posedge clk); #1;
    sif.in_valid = 1'b0;
    check_vec("b2b_ov_run", 64'(sif.out_valid), 64'd0);
    check_vec("b2b_rdy_run", 64'(sif.in_ready), 64'd0);
    lat = 0;
    while (!sif.out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    check_vec("b2b_lat1", 64'(lat), 64'd4);
    check_vec("b2b_T1", 64'(sif.T), 64'd10);
    check_vec("b2b_rdy1", 64'(sif.in_ready), 64'd1);
    @(posedge clk); #1;
    check_vec("b2b_idle_ov", 64'(sif.out_valid), 64'd0);
    check_vec("b2b_idle_rdy", 64'(sif.in_ready), 64'd1);

    // Backpressure: result must hold while out_ready is low.
    sif.q = 4'd13; sif.a = 4'd5; sif.in_valid = 1'b1; sif.out_ready = 1'b0;
    @(posedge clk); #1;
    sif.a = 4'd0;
    lat = 0;
    while (!sif.out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    check_vec("bp_lat", 64'(lat), 64'd4);
    for (int i = 0; i < 10; i++) begin
      check_vec("bp_ov", 64'(sif.out_valid), 64'd1);
      check_vec("bp_T", 64'(sif.T), 64'd2);
      check_vec("bp_rdy", 64'(sif.in_ready), 64'd0);
      @(posedge clk); #1;
    end
    sif.in_valid = 1'b0; sif.out_ready = 1'b1;
    @(posedge clk); #1;
    check_vec("bp_ret", 64'(sif.out_valid), 64'd0);

    // Reset during RUN cycle 2 discards the operation.
    sif.q = 4'd13; sif.a = 4'd5; sif.in_valid = 1'b1; sif.out_ready = 1'b1;
    @(posedge clk); #1;
    sif.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_s = 1'b1;
    #1;
    check_vec("mrst_rdy", 64'(sif.in_ready), 64'd1);
    check_vec("mrst_ov", 64'(sif.out_valid), 64'd0);
    check_vec("mrst_T", 64'(sif.T), 64'd0);
    @(posedge clk); #1;
    rst_s = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (sif.out_valid) seen++;
      @(posedge clk); #1;
    end
    check_vec("mrst_no_out", 64'(seen), 64'd0);
    small_op(4'd5, 4'd2, "post_rst");

    // Default-size instance against (a * 2^60) mod q.
    for (int i = 0; i < 3000; i++) begin
      r  = {$urandom(), $urandom()};
      qv = r[59:0] | 60'd1;
      if (i == 0) qv = 60'hfff_ffff_ffff_ffff;
      r  = {$urandom(), $urandom()};
      av = 60'(r[59:0] % qv);
      if ($urandom_range(1) == 1) begin
        sum = {1'b0, av} + {1'b0, qv};
        if (!sum[60]) av = sum[59:0];
      end
      prod = {av, 60'd0};
      ev   = 60'(prod % 120'(qv));
      big_op(qv, av, ev);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
